// File: rtl/writeback_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : pipeline_defs
//  Description: Shared widths and the write-back entry type for the WB stage.
//  Revision   : 1.0 - initial release
// ============================================================================
package pipeline_defs;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module     : wb_result_fifo
//  Description: Circular FIFO of pending MDU results with per-entry visibility.
//  Revision   : 1.0 - initial release
// ============================================================================
module wb_result_fifo
    import pipeline_defs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  wb_entry_t                        push_entry,
    input  logic                             pop,
    output logic                             full,
    output logic                             empty,
    output wb_entry_t                        head,
    output logic [DEPTH-1:0]                 ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]     ent_dest
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t              r_mem [DEPTH];
    logic [DEPTH-1:0]       r_vld;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            // Clear before set: a full push/pop hits the same slot and must stay valid
            if (pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= next_ptr(r_rd_ptr);
            end
            if (push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (push && !pop)
                r_count <= r_count + CNT_W'(1);
            else if (pop && !push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            r_mem[r_wr_ptr] <= push_entry;
    end

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign ent_valid = r_vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_dest[i] = r_mem[i].dest;
    end

endmodule
`default_nettype wire

// File: rtl/writeback_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : writeback_port_ctrl
//  Description: MEM/WB register plus MDU result merge onto the RF write port.
//  Revision   : 1.0 - initial release
// ============================================================================
module writeback_port_ctrl
    import pipeline_defs::*;
#(
    parameter int DATA_W    = pipeline_defs::DATA_W,
    parameter int ADDR_W    = pipeline_defs::ADDR_W,
    parameter int MDU_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_mem_to_reg,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    output logic              wb_stall,
    input  logic              mdu_valid,
    output logic              mdu_ready,
    input  logic [ADDR_W-1:0] mdu_dest,
    input  logic [DATA_W-1:0] mdu_result,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    output logic [31:0]       mdu_pending
);

    logic                               r_wb_valid;
    wb_entry_t                          r_wb;

    logic                               w_pipe_wr;
    logic                               w_push;
    logic                               w_pop;
    logic                               w_full;
    logic                               w_empty;
    wb_entry_t                          w_head;
    logic [MDU_DEPTH-1:0]               w_ent_valid;
    logic [MDU_DEPTH-1:0][ADDR_W-1:0]   w_ent_dest;
    logic [31:0]                        w_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb       <= '0;
        end else if (wb_stall) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= mem_valid & mem_reg_write;
            r_wb.dest  <= mem_dest;
            r_wb.data  <= mem_mem_to_reg ? mem_load_data : mem_alu_result;
        end
    end

    assign w_pipe_wr = r_wb_valid & (r_wb.dest != REG_ZERO);
    assign w_pop     = ~w_pipe_wr & ~w_empty;
    assign mdu_ready = ~reset & (~w_full | w_pop);
    // Dest-0 results still complete the handshake but are dropped here
    assign w_push    = mdu_valid & mdu_ready & (mdu_dest != REG_ZERO);
    assign wb_stall  = w_full & ~w_pop;

    wb_result_fifo #(
        .DEPTH      (MDU_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_entry ({mdu_dest, mdu_result}),
        .pop        (w_pop),
        .full       (w_full),
        .empty      (w_empty),
        .head       (w_head),
        .ent_valid  (w_ent_valid),
        .ent_dest   (w_ent_dest)
    );

    always_comb begin
        reg_write_en   = 1'b0;
        reg_write_dest = '0;
        reg_write_data = '0;
        if (w_pipe_wr) begin
            reg_write_en   = 1'b1;
            reg_write_dest = r_wb.dest;
            reg_write_data = r_wb.data;
        end else if (!w_empty) begin
            reg_write_en   = 1'b1;
            reg_write_dest = w_head.dest;
            reg_write_data = w_head.data;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < MDU_DEPTH; i++) begin
            if (w_ent_valid[i])
                w_pending[w_ent_dest[i]] = 1'b1;
        end
    end

    assign mdu_pending = {w_pending[31:1], 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_writeback_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tb_writeback_port_ctrl
//  Description: Directed self-checking bench for writeback_port_ctrl.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_writeback_port_ctrl;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_reg_write;
    logic        mem_mem_to_reg;
    logic [4:0]  mem_dest;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic        wb_stall;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_dest;
    logic [31:0] mdu_result;
    logic        reg_write_en;
    logic [4:0]  reg_write_dest;
    logic [31:0] reg_write_data;
    logic [31:0] mdu_pending;

    int checks;
    int failures;

    writeback_port_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .mem_dest       (mem_dest),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .wb_stall       (wb_stall),
        .mdu_valid      (mdu_valid),
        .mdu_ready      (mdu_ready),
        .mdu_dest       (mdu_dest),
        .mdu_result     (mdu_result),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .mdu_pending    (mdu_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_mem(input logic v, input logic m2r, input logic [4:0] d,
                             input logic [31:0] alu, input logic [31:0] ld);
        mem_valid      = v;
        mem_reg_write  = 1'b1;
        mem_mem_to_reg = m2r;
        mem_dest       = d;
        mem_alu_result = alu;
        mem_load_data  = ld;
    endtask

    task automatic drive_mdu(input logic v, input logic [4:0] d, input logic [31:0] r);
        mdu_valid  = v;
        mdu_dest   = d;
        mdu_result = r;
    endtask

    task automatic test_reset;
        @(negedge clk);
        drive_mdu(1'b1, 5'd3, 32'h3);
        #1;
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", reg_write_en); end
        checks++; if (mdu_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", mdu_ready); end
        checks++; if (mdu_pending !== 32'h0 || wb_stall !== 1'b0) begin failures++; $display("FAIL reset_pend_stall got=%h/%0b exp=0/0", mdu_pending, wb_stall); end
        drive_mdu(1'b0, 5'd0, 32'h0);
        reset = 1'b0;
        #1;
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%0b exp=1", mdu_ready); end
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL release_en got=%0b exp=0", reg_write_en); end
    endtask

    task automatic test_reset_mid_write;
        drive_mem(1'b1, 1'b0, 5'd5, 32'h7, 32'h0);
        drive_mdu(1'b1, 5'd9, 32'h3);
        @(negedge clk);
        drive_mem(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        drive_mdu(1'b0, 5'd0, 32'h0);
        checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 5'd5) begin failures++; $display("FAIL midrst_pre got=%0b/%0d exp=1/5", reg_write_en, reg_write_dest); end
        checks++; if (mdu_pending !== 32'h0000_0200) begin failures++; $display("FAIL midrst_pend got=%h exp=00000200", mdu_pending); end
        #1 reset = 1'b1;
        #1;
        checks++; if (reg_write_en !== 1'b0 || reg_write_dest !== 5'd0 || reg_write_data !== 32'h0) begin failures++; $display("FAIL midrst_out got=%0b/%0d/%h exp=0/0/0", reg_write_en, reg_write_dest, reg_write_data); end
        checks++; if (mdu_pending !== 32'h0 || mdu_ready !== 1'b0 || wb_stall !== 1'b0) begin failures++; $display("FAIL midrst_side got=%h/%0b/%0b exp=0/0/0", mdu_pending, mdu_ready, wb_stall); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%0b exp=1", mdu_ready); end
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL midrst_spurious got=%0b exp=0", reg_write_en); end
    endtask

    task automatic test_pipeline;
        drive_mem(1'b1, 1'b0, 5'd16, 32'h0000_000A, 32'h55);
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 5'd16 || reg_write_data !== 32'hA) begin failures++; $display("FAIL pipe_alu got=%0b/%0d/%h exp=1/16/0000000a", reg_write_en, reg_write_dest, reg_write_data); end
        drive_mem(1'b1, 1'b1, 5'd16, 32'h0000_000A, 32'h55);
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 5'd16 || reg_write_data !== 32'h55) begin failures++; $display("FAIL pipe_load got=%0b/%0d/%h exp=1/16/00000055", reg_write_en, reg_write_dest, reg_write_data); end
        drive_mem(1'b0, 1'b0, 5'd16, 32'hA, 32'h55);
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL pipe_idle got=%0b exp=0", reg_write_en); end
    endtask

    task automatic test_reg_zero;
        drive_mem(1'b1, 1'b0, 5'd0, 32'h99, 32'h0);
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL r0_pipe got=%0b exp=0", reg_write_en); end
        drive_mem(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        drive_mdu(1'b1, 5'd0, 32'h77);
        #1;
        checks++; if (mdu_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%0b exp=1", mdu_ready); end
        @(negedge clk);
        drive_mdu(1'b0, 5'd0, 32'h0);
        checks++; if (mdu_pending !== 32'h0 || reg_write_en !== 1'b0) begin failures++; $display("FAIL r0_mdu got=%h/%0b exp=0/0", mdu_pending, reg_write_en); end
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0) begin failures++; $display("FAIL r0_after got=%0b exp=0", reg_write_en); end
    endtask

    task automatic test_mdu_idle;
        drive_mdu(1'b1, 5'd17, 32'd12);
        @(negedge clk);
        drive_mdu(1'b0, 5'd0, 32'h0);
        checks++; if (mdu_pending !== 32'h0002_0000) begin failures++; $display("FAIL idle_pend got=%h exp=00020000", mdu_pending); end
        checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 5'd17 || reg_write_data !== 32'd12) begin failures++; $display("FAIL idle_wr got=%0b/%0d/%0d exp=1/17/12", reg_write_en, reg_write_dest, reg_write_data); end
        @(negedge clk);
        checks++; if (mdu_pending !== 32'h0 || reg_write_en !== 1'b0) begin failures++; $display("FAIL idle_drain got=%h/%0b exp=0/0", mdu_pending, reg_write_en); end
    endtask

    task automatic test_starvation;
        drive_mem(1'b1, 1'b0, 5'd1, 32'h101, 32'h0);
        drive_mdu(1'b1, 5'd18, 32'h18);
        @(negedge clk);
        checks++; if (reg_write_dest !== 5'd1 || wb_stall !== 1'b0) begin failures++; $display("FAIL starve_c1 got=%0d/%0b exp=1/0", reg_write_dest, wb_stall); end
        drive_mem(1'b1, 1'b0, 5'd2, 32'h102, 32'h0);
        drive_mdu(1'b1, 5'd19, 32'h19);
        @(negedge clk);
        checks++; if (reg_write_dest !== 5'd2 || wb_stall !== 1'b1 || mdu_ready !== 1'b0) begin failures++; $display("FAIL starve_full got=%0d/%0b/%0b exp=2/1/0", reg_write_dest, wb_stall, mdu_ready); end
        checks++; if (mdu_pending !== 32'h000C_0000) begin failures++; $display("FAIL starve_pend got=%h exp=000c0000", mdu_pending); end
        drive_mem(1'b1, 1'b0, 5'd3, 32'h103, 32'h0);
        drive_mdu(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checks++; if (reg_write_dest !== 5'd18 || reg_write_data !== 32'h18 || wb_stall !== 1'b0) begin failures++; $display("FAIL starve_mdu18 got=%0d/%h/%0b exp=18/00000018/0", reg_write_dest, reg_write_data, wb_stall); end
        @(negedge clk);
        checks++; if (reg_write_dest !== 5'd3 || reg_write_data !== 32'h103) begin failures++; $display("FAIL starve_held got=%0d/%h exp=3/00000103", reg_write_dest, reg_write_data); end
        drive_mem(1'b1, 1'b0, 5'd4, 32'h104, 32'h0);
        @(negedge clk);
        checks++; if (reg_write_dest !== 5'd4 || mdu_pending !== 32'h0008_0000) begin failures++; $display("FAIL starve_c4 got=%0d/%h exp=4/00080000", reg_write_dest, mdu_pending); end
        drive_mem(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 5'd19 || reg_write_data !== 32'h19) begin failures++; $display("FAIL starve_mdu19 got=%0b/%0d/%h exp=1/19/00000019", reg_write_en, reg_write_dest, reg_write_data); end
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0 || mdu_pending !== 32'h0) begin failures++; $display("FAIL starve_end got=%0b/%h exp=0/0", reg_write_en, mdu_pending); end
    endtask

    task automatic test_full_push_pop;
        drive_mem(1'b1, 1'b0, 5'd1, 32'h201, 32'h0);
        drive_mdu(1'b1, 5'd20, 32'h20);
        @(negedge clk);
        drive_mem(1'b1, 1'b0, 5'd2, 32'h202, 32'h0);
        drive_mdu(1'b1, 5'd21, 32'h21);
        @(negedge clk);
        drive_mem(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        drive_mdu(1'b1, 5'd22, 32'h22);
        #1;
        checks++; if (mdu_ready !== 1'b0 || wb_stall !== 1'b1) begin failures++; $display("FAIL fpp_blocked got=%0b/%0b exp=0/1", mdu_ready, wb_stall); end
        @(negedge clk);
        checks++; if (reg_write_dest !== 5'd20 || mdu_ready !== 1'b1 || wb_stall !== 1'b0) begin failures++; $display("FAIL fpp_pop got=%0d/%0b/%0b exp=20/1/0", reg_write_dest, mdu_ready, wb_stall); end
        checks++; if (mdu_pending !== 32'h0030_0000) begin failures++; $display("FAIL fpp_pend1 got=%h exp=00300000", mdu_pending); end
        @(negedge clk);
        drive_mdu(1'b0, 5'd0, 32'h0);
        checks++; if (reg_write_dest !== 5'd21 || reg_write_data !== 32'h21 || mdu_pending !== 32'h0060_0000) begin failures++; $display("FAIL fpp_swap got=%0d/%h/%h exp=21/00000021/00600000", reg_write_dest, reg_write_data, mdu_pending); end
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b1 || reg_write_dest !== 5'd22 || reg_write_data !== 32'h22) begin failures++; $display("FAIL fpp_new got=%0b/%0d/%h exp=1/22/00000022", reg_write_en, reg_write_dest, reg_write_data); end
        @(negedge clk);
        checks++; if (reg_write_en !== 1'b0 || mdu_pending !== 32'h0) begin failures++; $display("FAIL fpp_end got=%0b/%h exp=0/0", reg_write_en, mdu_pending); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drive_mem(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        drive_mdu(1'b0, 5'd0, 32'h0);
        test_reset();
        test_reset_mid_write();
        test_pipeline();
        test_reg_zero();
        test_mdu_idle();
        test_starvation();
        test_full_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
